// File: rtl/corescore_uart_pkg.sv
// Purpose: shared UART receive definitions -- FSM state encoding, default
// bit timing, default end-of-packet character and the FIFO entry payload.
package corescore_uart_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT  = 278;    // 16 MHz / 57600
  localparam logic [7:0]  LAST_CHAR_DEFAULT = 8'h0A;
  localparam int unsigned FRAME_BITS        = 8;
  localparam int unsigned DATA_W            = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // One received byte plus its end-of-packet marker, as held in the FIFO.
  typedef struct packed {
    logic              tlast;
    logic [DATA_W-1:0] tdata;
  } axis_beat_t;

endpackage

// File: rtl/uart_rx_axis_if.sv
// Purpose: AXI4-Stream byte channel carrying received UART data.
//   tdata  [7:0]  byte          (master -> slave)
//   tlast         end of packet (master -> slave)
//   tvalid        beat present  (master -> slave)
//   tready        accept        (slave  -> master)
interface uart_rx_axis_if import corescore_uart_pkg::*; ();

  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: synchronous FIFO of {tlast,tdata} entries between the UART
// deserialiser and the stream output.
//   i_clk, i_rst_n   clock, async active-low reset (empties FIFO)
//   i_wr, i_wdata    push request and entry
//   i_rd             pop request (ignored when empty)
//   o_rdata_c        head entry
//   o_full_c         no free entries
//   o_empty_c        no entries
module uart_rx_fifo
  import corescore_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr,
  input  axis_beat_t i_wdata,
  input  logic       i_rd,
  output axis_beat_t o_rdata_c,
  output logic       o_full_c,
  output logic       o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  axis_beat_t      r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            w_do_rd;
  logic            w_do_wr;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty_c = (r_wr_ptr == r_rd_ptr);
  assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rdata_c = r_mem[r_rd_ptr[AW-1:0]];

  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign w_do_rd = i_rd && !o_empty_c;
  assign w_do_wr = i_wr && (!o_full_c || w_do_rd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_axis.sv
// Purpose: 8N1 UART receiver presenting bytes as an AXI4-Stream master.
//   i_clk        sole clock
//   i_rst_n      async active-low reset; aborts any frame, empties the FIFO
//   i_uart_rx    serial input, idle high, asynchronous
//   m_axis       stream output (tdata/tlast/tvalid from FIFO head, tready in)
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overflow   one-cycle pulse: good byte dropped because FIFO was full
module uart_rx_axis
  import corescore_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  LAST_CHAR  = LAST_CHAR_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_uart_rx,
  uart_rx_axis_if.master m_axis,
  output logic           o_frame_err,
  output logic           o_overflow
);

  localparam int unsigned CNT_W  = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W  = $clog2(FRAME_BITS);
  localparam int unsigned HALF_M1 = BAUD_DIV / 2 - 1;
  localparam int unsigned FULL_M1 = BAUD_DIV - 1;

  logic [1:0]        r_sync;
  logic              w_rx_s;
  rx_state_e         r_state,   w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [BIT_W-1:0]  r_bit,     w_bit_nxt;
  logic [DATA_W-1:0] r_shift,   w_shift_nxt;
  logic              w_push_c;
  logic              w_ferr_c;
  logic              w_pop;
  logic              w_drop;
  logic              w_full_c;
  logic              w_empty_c;
  axis_beat_t        w_wdata;
  axis_beat_t        w_rdata_c;

  // Two-flop synchroniser, preset to the idle line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_uart_rx};
  end
  assign w_rx_s = r_sync[1];

  // Frame FSM and its counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next state: start sampled at half a bit, data/stop one full bit apart.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push_c    = 1'b0;
    w_ferr_c    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(HALF_M1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(FULL_M1)) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[DATA_W-1:1]};
          w_bit_nxt   = r_bit + BIT_W'(1);
          if (r_bit == BIT_W'(FRAME_BITS - 1)) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(FULL_M1)) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_push_c    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_c    = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_wdata.tdata = r_shift;
  assign w_wdata.tlast = (r_shift == LAST_CHAR);

  assign w_pop  = m_axis.tvalid && m_axis.tready;
  assign w_drop = w_push_c && w_full_c && !w_pop;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr      (w_push_c),
    .i_wdata   (w_wdata),
    .i_rd      (w_pop),
    .o_rdata_c (w_rdata_c),
    .o_full_c  (w_full_c),
    .o_empty_c (w_empty_c)
  );

  assign m_axis.tdata  = w_rdata_c.tdata;
  assign m_axis.tlast  = w_rdata_c.tlast;
  assign m_axis.tvalid = !w_empty_c;

  // Status pulses; push and frame error are exclusive so these never coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_frame_err <= w_ferr_c;
      o_overflow  <= w_drop;
    end
  end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Purpose: self-checking bench for uart_rx_axis; expected beats are queued
// when frames are sent and compared as the stream output hands them over.
module tb_uart_rx_axis;

  localparam int unsigned BAUD = 278;

  logic clk;
  logic rst_n;
  logic rx;
  logic frame_err;
  logic overflow;

  uart_rx_axis_if axis_if ();

  uart_rx_axis #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (4),
    .LAST_CHAR  (8'h0A)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_uart_rx   (rx),
    .m_axis      (axis_if),
    .o_frame_err (frame_err),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;

  logic [8:0] exp_q [$];

  logic       held;
  logic [7:0] held_data;
  logic       held_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop, hold stability, pulse counting.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_tdata", 32'(axis_if.tdata), 32'(held_data));
        chk("hold_tlast", 32'(axis_if.tlast), 32'(held_last));
      end
      if (axis_if.tvalid && axis_if.tready) begin
        logic [8:0] e;
        beats++;
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_tdata", 32'(axis_if.tdata), 32'(e[7:0]));
          chk("beat_tlast", 32'(axis_if.tlast), 32'(e[8]));
        end
      end
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
      if (frame_err || overflow)
        chk("err_ovf_exclusive", 32'(frame_err & overflow), 32'd0);
      held      = axis_if.tvalid && !axis_if.tready;
      held_data = axis_if.tdata;
      held_last = axis_if.tlast;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BAUD);
    end
    rx = stop;
    idle(BAUD);
    rx = 1'b1;
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back({(b == 8'h0A), b});
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 * int'(BAUD) && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(exp_q.size()), 32'd0);
    idle(2 * BAUD);
  endtask

  int b_beats, b_ferr, b_ovf;

  initial begin
    rx    = 1'b1;
    axis_if.tready = 1'b1;
    rst_n = 1'b0;
    idle(5);
    chk("rst_tvalid",    32'(axis_if.tvalid), 32'd0);
    chk("rst_tdata",     32'(axis_if.tdata),  32'd0);
    chk("rst_tlast",     32'(axis_if.tlast),  32'd0);
    chk("rst_frame_err", 32'(frame_err),      32'd0);
    chk("rst_overflow",  32'(overflow),       32'd0);
    rst_n = 1'b1;
    idle(10);

    // Single byte
    b_ferr = ferr_cnt; b_ovf = ovf_cnt; b_beats = beats;
    expect_byte(8'h55);
    send_byte(8'h55, 1'b1);
    wait_drain("t1_drain");
    chk("t1_beats",  32'(beats - b_beats),    32'd1);
    chk("t1_ferr",   32'(ferr_cnt - b_ferr),  32'd0);
    chk("t1_ovf",    32'(ovf_cnt - b_ovf),    32'd0);
    chk("t1_tvalid", 32'(axis_if.tvalid),     32'd0);

    // Back-to-back "hi\n"
    b_beats = beats;
    expect_byte(8'h68); expect_byte(8'h69); expect_byte(8'h0A);
    send_byte(8'h68, 1'b1);
    send_byte(8'h69, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_drain("t2_drain");
    chk("t2_beats", 32'(beats - b_beats), 32'd3);

    // Back-pressure: fifth byte overflows
    b_beats = beats; b_ovf = ovf_cnt;
    axis_if.tready = 1'b0;
    expect_byte(8'h01); expect_byte(8'h02); expect_byte(8'h03); expect_byte(8'h04);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    idle(BAUD);
    chk("t3_ovf",        32'(ovf_cnt - b_ovf),  32'd1);
    chk("t3_no_beats",   32'(beats - b_beats),  32'd0);
    chk("t3_tvalid",     32'(axis_if.tvalid),   32'd1);
    axis_if.tready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_beats", 32'(beats - b_beats), 32'd4);

    // Framing error then good byte
    b_beats = beats; b_ferr = ferr_cnt;
    send_byte(8'hA3, 1'b0);
    idle(2 * BAUD);
    chk("t4_ferr",     32'(ferr_cnt - b_ferr), 32'd1);
    chk("t4_no_beat",  32'(beats - b_beats),   32'd0);
    expect_byte(8'h11);
    send_byte(8'h11, 1'b1);
    wait_drain("t4_drain");
    chk("t4_beats",    32'(beats - b_beats),   32'd1);
    chk("t4_ferr_one", 32'(ferr_cnt - b_ferr), 32'd1);

    // Short glitch on idle line
    b_beats = beats; b_ferr = ferr_cnt; b_ovf = ovf_cnt;
    rx = 1'b0;
    idle(BAUD / 4);
    rx = 1'b1;
    idle(12 * BAUD);
    chk("t5_beats", 32'(beats - b_beats),   32'd0);
    chk("t5_ferr",  32'(ferr_cnt - b_ferr), 32'd0);
    chk("t5_ovf",   32'(ovf_cnt - b_ovf),   32'd0);

    // Reset mid-DATA with two bytes queued
    b_beats = beats;
    axis_if.tready = 1'b0;
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    rx = 1'b0;
    idle(BAUD);
    rx = 1'b1;
    idle(3 * BAUD);
    chk("t6_tvalid_before", 32'(axis_if.tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_tvalid_rst", 32'(axis_if.tvalid), 32'd0);
    idle(5);
    rst_n = 1'b1;
    axis_if.tready = 1'b1;
    idle(12 * BAUD);
    chk("t6_no_stale", 32'(beats - b_beats), 32'd0);
    expect_byte(8'h3C);
    send_byte(8'h3C, 1'b1);
    wait_drain("t6_drain");
    chk("t6_beats", 32'(beats - b_beats), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
